// File: rtl/nn_stream_pkg.sv
// Shared types for the layer stream driver: FSM state encoding and the default data word.
package nn_stream_pkg;

   localparam int T_DEF = 32;

   typedef logic signed [T_DEF-1:0] word_t;

   typedef enum logic [1:0] {LOAD, SEND, COLLECT, DONE} state_e;

endpackage

// File: rtl/layer_stream_driver_if.sv
// Host load port, layer tx/rx streams and result readback of the layer stream driver.
interface layer_stream_driver_if #(
   parameter int T       = 32,
   parameter int LOG_OUT = 4
);
   logic               ld_valid;
   logic [T-1:0]       ld_data;
   logic               ld_ready;
   logic               tx_valid;
   logic [T-1:0]       tx_data;
   logic               tx_ready;
   logic               rx_valid;
   logic [T-1:0]       rx_data;
   logic               rx_ready;
   logic [LOG_OUT-1:0] rd_addr;
   logic [T-1:0]       rd_data;
   logic               done;
   logic               relu_err;

   // master: the driver itself; slave: host plus layer side
   modport master (
      input  ld_valid, ld_data, tx_ready, rx_valid, rx_data, rd_addr,
      output ld_ready, tx_valid, tx_data, rx_ready, rd_data, done, relu_err
   );

   modport slave (
      output ld_valid, ld_data, tx_ready, rx_valid, rx_data, rd_addr,
      input  ld_ready, tx_valid, tx_data, rx_ready, rd_data, done, relu_err
   );
endinterface

// File: rtl/stream_buf.sv
// Register array with one write port, one combinational read port and one registered read port.
module stream_buf #(
   parameter int W     = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata,
   input  logic [AW-1:0] i_qaddr,
   output logic [W-1:0]  o_qdata
);
   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_q;

   // contents are deliberately left uncleared by reset
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) r_q <= '0;
      else       r_q <= r_mem[i_qaddr];
   end

   assign o_rdata = r_mem[i_raddr];
   assign o_qdata = r_q;
endmodule

// File: rtl/layer_stream_driver.sv
// Loads one input vector, streams it into a layer, collects its results and pulses done.
// LAYER_DRIVER_RELU_CHECK_EN builds the sticky negative-result flag relu_err.
module layer_stream_driver
   import nn_stream_pkg::*;
#(
   parameter int T       = T_DEF,
   parameter int N_IN    = 16,
   parameter int N_OUT   = 13,
   parameter int LOG_IN  = 4,
   parameter int LOG_OUT = 4
) (
   input logic                   clk,
   input logic                   reset,
   layer_stream_driver_if.master bus
);
   localparam logic [LOG_IN-1:0]  IN_LAST  = LOG_IN'(N_IN - 1);
   localparam logic [LOG_OUT-1:0] OUT_LAST = LOG_OUT'(N_OUT - 1);

   state_e             r_state, w_next;
   logic [LOG_IN-1:0]  r_ld_cnt, r_tx_cnt;
   logic [LOG_OUT-1:0] r_rx_cnt;
   logic               w_ld_ready, w_tx_valid, w_rx_ready, w_done;
   logic               w_ld_fire, w_tx_fire, w_rx_fire;
   logic [T-1:0]       w_unused_in_q, w_unused_out_c;

   always_ff @(posedge clk) begin
      if (reset) r_state <= LOAD;
      else       r_state <= w_next;
   end

   // handshake outputs decode the state register only
   always_comb begin
      w_next     = r_state;
      w_ld_ready = 1'b0;
      w_tx_valid = 1'b0;
      w_rx_ready = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         LOAD: begin
            w_ld_ready = 1'b1;
            if (bus.ld_valid && r_ld_cnt == IN_LAST) w_next = SEND;
         end
         SEND: begin
            w_tx_valid = 1'b1;
            if (bus.tx_ready && r_tx_cnt == IN_LAST) w_next = COLLECT;
         end
         COLLECT: begin
            w_rx_ready = 1'b1;
            if (bus.rx_valid && r_rx_cnt == OUT_LAST) w_next = DONE;
         end
         DONE: begin
            w_done = 1'b1;
            w_next = LOAD;
         end
         default: w_next = LOAD;
      endcase
   end

   assign w_ld_fire = w_ld_ready & bus.ld_valid;
   assign w_tx_fire = w_tx_valid & bus.tx_ready;
   assign w_rx_fire = w_rx_ready & bus.rx_valid;

   always_ff @(posedge clk) begin
      if (reset || r_state == DONE) begin
         r_ld_cnt <= '0;
         r_tx_cnt <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_ld_fire) r_ld_cnt <= (r_ld_cnt == IN_LAST)  ? '0 : r_ld_cnt + 1'b1;
         if (w_tx_fire) r_tx_cnt <= (r_tx_cnt == IN_LAST)  ? '0 : r_tx_cnt + 1'b1;
         if (w_rx_fire) r_rx_cnt <= (r_rx_cnt == OUT_LAST) ? '0 : r_rx_cnt + 1'b1;
      end
   end

   assign bus.ld_ready = w_ld_ready;
   assign bus.tx_valid = w_tx_valid;
   assign bus.rx_ready = w_rx_ready;
   assign bus.done     = w_done;

   // the spare read port of each buffer is left dangling and trimmed by synthesis
   stream_buf #(.W(T), .DEPTH(N_IN), .AW(LOG_IN)) u_in_buf (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_ld_fire),
      .i_waddr (r_ld_cnt),
      .i_wdata (bus.ld_data),
      .i_raddr (r_tx_cnt),
      .o_rdata (bus.tx_data),
      .i_qaddr (r_tx_cnt),
      .o_qdata (w_unused_in_q)
   );

   stream_buf #(.W(T), .DEPTH(N_OUT), .AW(LOG_OUT)) u_out_buf (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_rx_fire),
      .i_waddr (r_rx_cnt),
      .i_wdata (bus.rx_data),
      .i_raddr (bus.rd_addr),
      .o_rdata (w_unused_out_c),
      .i_qaddr (bus.rd_addr),
      .o_qdata (bus.rd_data)
   );

`ifdef LAYER_DRIVER_RELU_CHECK_EN
   logic r_relu_err;

   always_ff @(posedge clk) begin
      if (reset)                             r_relu_err <= 1'b0;
      else if (w_rx_fire && bus.rx_data[T-1]) r_relu_err <= 1'b1;
      else if (w_ld_fire)                    r_relu_err <= 1'b0;
   end

   assign bus.relu_err = r_relu_err;
`else
   assign bus.relu_err = 1'b0;
`endif
endmodule

// File: tb/tb_layer_stream_driver.sv
// Directed bench for layer_stream_driver: transfer-level model checked every cycle plus literal expectations.
module tb_layer_stream_driver;
   import nn_stream_pkg::*;

   localparam int N_IN  = 16;
   localparam int N_OUT = 13;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   layer_stream_driver_if bus ();

   layer_stream_driver #(
      .T(32), .N_IN(N_IN), .N_OUT(N_OUT), .LOG_IN(4), .LOG_OUT(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   bit    chk_en   = 1'b0;
   bit    tx_alt   = 1'b0;
   bit    rx_gaps  = 1'b0;
   word_t rx_q[$];

   // transfer-level model: counts of words moved in each phase of the current vector
   int    m_ld = 0, m_tx = 0, m_rx = 0;
   int    done_cnt = 0, tx_total = 0, last_ld_cyc = 0;
   word_t m_vec[N_IN];
   word_t m_res[N_OUT];
   bit    m_res_ok[N_OUT];
   bit    m_relu    = 1'b0;
   word_t exp_rd    = '0;
   bit    exp_rd_ok = 1'b0;
   word_t tx_log[$];
   int    tx_cyc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, $signed(act), act, $signed(exp), exp, cyc);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b, expected %0b at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: expected event did not occur within bound at cycle %0d", name, cyc);
   endtask

   always @(negedge clk) begin
      bit ph_ld, ph_tx, ph_rx, ph_dn;
      cyc++;
      ph_ld = (m_ld < N_IN);
      ph_tx = (m_ld == N_IN) && (m_tx < N_IN);
      ph_rx = (m_tx == N_IN) && (m_rx < N_OUT);
      ph_dn = (m_rx == N_OUT);
      if (chk_en) begin
         chkb("ld_ready", bus.ld_ready, ph_ld);
         chkb("tx_valid", bus.tx_valid, ph_tx);
         chkb("rx_ready", bus.rx_ready, ph_rx);
         chkb("done",     bus.done,     ph_dn);
         chkb("relu_err", bus.relu_err, m_relu);
         if (ph_tx)     chk("tx_data", bus.tx_data, m_vec[m_tx]);
         if (exp_rd_ok) chk("rd_data", bus.rd_data, exp_rd);
      end
      if (bus.rd_addr < N_OUT && m_res_ok[bus.rd_addr]) begin
         exp_rd    = m_res[bus.rd_addr];
         exp_rd_ok = 1'b1;
      end else begin
         exp_rd_ok = 1'b0;
      end
      if (reset) begin
         m_ld = 0; m_tx = 0; m_rx = 0;
         m_relu    = 1'b0;
         exp_rd    = '0;
         exp_rd_ok = 1'b1;
      end else begin
         if (ph_ld && bus.ld_valid) begin
            m_vec[m_ld] = bus.ld_data;
            m_ld++;
            last_ld_cyc = cyc;
            m_relu = 1'b0;
         end
         if (ph_tx && bus.tx_ready) begin
            tx_log.push_back(bus.tx_data);
            tx_cyc.push_back(cyc);
            tx_total++;
            m_tx++;
         end
         if (ph_rx && bus.rx_valid) begin
            m_res[m_rx]    = bus.rx_data;
            m_res_ok[m_rx] = 1'b1;
`ifdef LAYER_DRIVER_RELU_CHECK_EN
            if (bus.rx_data[31]) m_relu = 1'b1;
`endif
            m_rx++;
         end
         if (ph_dn) begin
            m_ld = 0; m_tx = 0; m_rx = 0;
            done_cnt++;
         end
      end
   end

   // layer output side: presents queued words, holding each until accepted
   initial begin
      bit fired;
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;
      forever begin
         @(negedge clk);
         fired = bus.rx_valid && bus.rx_ready;
         @(posedge clk);
         #1;
         if (fired) begin
            void'(rx_q.pop_front());
            bus.rx_valid = 1'b0;
         end
         if (!bus.rx_valid && rx_q.size() > 0 && (!rx_gaps || $urandom_range(0, 2) == 0)) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = rx_q[0];
         end
      end
   end

   initial begin
      bus.tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (tx_alt) bus.tx_ready = ~bus.tx_ready;
         else        bus.tx_ready = 1'b1;
      end
   end

   task automatic load_vec(input int base);
      for (int i = 0; i < N_IN; i++) begin
         int t = 0;
         bus.ld_valid = 1'b1;
         bus.ld_data  = 32'(base + i);
         @(negedge clk);
         while (!bus.ld_ready && t < 500) begin
            @(negedge clk);
            t++;
         end
         if (!bus.ld_ready) begin
            timeout("load_ready");
            bus.ld_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      bus.ld_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int t = 0;
      while (done_cnt == d0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      if (done_cnt == d0) timeout(name);
      #1;
   endtask

   task automatic wait_tx(input int target, input string name);
      int t = 0;
      while (tx_total < target && t < 2000) begin
         @(posedge clk);
         t++;
      end
      if (tx_total < target) timeout(name);
      #1;
   endtask

   task automatic push_rx(input int base);
      for (int i = 0; i < N_OUT; i++) rx_q.push_back(word_t'(base + i));
   endtask

   task automatic check_seq(input string name, input int start, input int base);
      chk({name, "_count"}, 32'(tx_log.size() - start), 32'(N_IN));
      if (tx_log.size() - start == N_IN)
         for (int i = 0; i < N_IN; i++) chk(name, tx_log[start + i], 32'(base + i));
   endtask

   task automatic read_back(input string name, input int base);
      for (int i = 0; i < N_OUT; i++) begin
         bus.rd_addr = 4'(i);
         @(posedge clk);
         @(negedge clk);
         chk(name, bus.rd_data, 32'(base + i));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int    start, d0, t0;
      logic  exp_relu;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      bus.rd_addr  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chkb("rst_ld_ready", bus.ld_ready, 1'b1);
      chkb("rst_tx_valid", bus.tx_valid, 1'b0);
      chkb("rst_rx_ready", bus.rx_ready, 1'b0);
      chkb("rst_done",     bus.done,     1'b0);
      chkb("rst_relu_err", bus.relu_err, 1'b0);
      chk ("rst_rd_data",  bus.rd_data,  32'd0);
      @(posedge clk);
      #1;

      // back-to-back send with rx words already pending before COLLECT
      tx_alt = 1'b0; rx_gaps = 1'b0;
      push_rx(100);
      start = tx_log.size(); d0 = done_cnt;
      load_vec(1);
      wait_done(d0, "t1_done");
      check_seq("t1_tx_seq", start, 1);
      if (tx_log.size() - start == N_IN) begin
         chk("t1_back_to_back",  32'(tx_cyc[start + 15] - tx_cyc[start]), 32'd15);
         chk("t1_first_tx_lat",  32'(tx_cyc[start] - last_ld_cyc),        32'd1);
      end
      read_back("t1_rd", 100);

      // stalled sender, gappy layer, and a stray load during SEND
      tx_alt = 1'b1; rx_gaps = 1'b1;
      push_rx(100);
      start = tx_log.size(); d0 = done_cnt; t0 = tx_total;
      load_vec(1);
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hDEAD;
      @(negedge clk);
      chkb("t6_ld_ready_send", bus.ld_ready, 1'b0);
      chkb("t6_tx_valid_send", bus.tx_valid, 1'b1);
      @(posedge clk);
      #1;
      wait_tx(t0 + N_IN, "t6_send_end");
      bus.ld_valid = 1'b0;
      wait_done(d0, "t3_done");
      repeat (5) @(posedge clk);
      #1;
      chk("t3_done_once", 32'(done_cnt - d0), 32'd1);
      check_seq("t2_tx_seq", start, 1);
      read_back("t3_rd", 100);

      // reset in the middle of SEND
      tx_alt = 1'b0; rx_gaps = 1'b0;
      t0 = tx_total;
      load_vec(61);
      wait_tx(t0 + 5, "t4_five_tx");
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chkb("t4_tx_valid_after_rst", bus.tx_valid, 1'b0);
      chkb("t4_ld_ready_after_rst", bus.ld_ready, 1'b1);
      chk ("t4_tx_count",           32'(tx_total - t0), 32'd5);
      @(posedge clk);
      #1;
      push_rx(300);
      start = tx_log.size(); d0 = done_cnt;
      load_vec(41);
      wait_done(d0, "t4_done");
      check_seq("t4_tx_seq", start, 41);
      read_back("t4_rd", 300);

      // negative result word
      for (int i = 0; i < N_OUT; i++) rx_q.push_back((i == 3) ? -32'sd5 : word_t'(100 + i));
      d0 = done_cnt;
      load_vec(1);
      wait_done(d0, "t5_done");
`ifdef LAYER_DRIVER_RELU_CHECK_EN
      exp_relu = 1'b1;
`else
      exp_relu = 1'b0;
`endif
      bus.rd_addr = 4'd3;
      @(posedge clk);
      @(negedge clk);
      chk ("t5_rd_neg",       bus.rd_data,  32'hFFFF_FFFB);
      chkb("t5_relu_set",     bus.relu_err, exp_relu);
      @(posedge clk);
      #1;
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'd7;
      @(negedge clk);
      chkb("t5_relu_held",    bus.relu_err, exp_relu);
      @(posedge clk);
      #1;
      bus.ld_valid = 1'b0;
      @(negedge clk);
      chkb("t5_relu_cleared", bus.relu_err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
